one_wire_link_layer: RTL
========================

Name: one_wire_link_layer

Overview:
Bit/byte timing engine for the 1-Wire bus. It turns command-level requests into standard-speed 1-Wire reset/presence sequences and time slots, driving the open-drain pad through ow_out/ow_oe and sampling ow_in. It sits directly below the one-wire interface control stage. That stage issues reset, write-byte, read-byte and write-bit requests over a valid/ready handshake and receives the sampled data back.

Parameters:
CLK_PER_US, 50, clocks per microsecond (50 MHz system clock)
CNT_W, 16, phase counter width; must hold 480*CLK_PER_US

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  request valid
cmd_ready  output  1  engine idle, request accepted when valid&ready
cmd  input  2  00 reset/presence, 01 write byte, 10 read byte, 11 write bit
tx_byte  input  8  data for write byte; bit0 used for write bit
rsp_valid  output  1  one-cycle pulse, operation complete
rx_byte  output  8  bits sampled during slots, LSB first
presence  output  1  presence detected (reset cmd only)
short_err  output  1  bus still low at end of reset recovery
ow_in  input  1  sampled bus level
ow_out  output  1  pad data, constant 0
ow_oe  output  1  1 = pull bus low

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; ow_oe=0, ow_out=0, rsp_valid=0, rx_byte=0x00, presence=0, short_err=0. ow_oe drops in the same instant rst_n falls, including mid-slot.
- Timing notation: all times are in µs × CLK_PER_US clocks. A single phase counter (CNT_W bits) counts from 0 and is cleared on each state change.
- Handshake: cmd_ready = (state==IDLE), combinational. Acceptance latches cmd and tx_byte. Read byte latches 0xFF as the shift register value. Write bit latches 7 slots of padding internally so that only 1 slot runs.
- Requests while busy are not accepted; the source holds cmd_valid.
- ow_oe asserts the cycle after acceptance.
- State RST_LOW: ow_oe=1 for 480 µs, then go to RST_HIGH.
- State RST_HIGH: ow_oe=0 for 410 µs.
  - At 70 µs, sample: presence = ~ow_in.
  - At 410 µs, sample: short_err = ~ow_in.
  - Then go to DONE.
  - rx_byte is unchanged by a reset command.
- State SLOT_LOW: ow_oe=1 for 6 µs if the current shift bit is 1, else 60 µs.
- State SLOT_REL: ow_oe=0 until 70 µs after slot start.
  - At 13 µs after slot start (the 1-bit case), ow_in is sampled into the shift-in bit.
  - For 0-bits, the sample still occurs at 13 µs and reads 0.
- State SLOT_REC: ow_oe=0 for 5 µs. Then decrement the bit count; go to SLOT_LOW if bits remain, else go to DONE.
- Bit order: LSB first. The shift-in register fills from bit7 downward, so that after 8 slots rx_byte[0] = first sampled bit.
- Write bit: rx_byte = {7'b0, sample}.
- Write byte: rx_byte = read-back of the bus. A slave may override 1-bits.
- State DONE: rsp_valid=1 for one cycle, load rx_byte/presence/short_err outputs, go to IDLE.
  - cmd_ready rises the cycle after rsp_valid.
  - Outputs hold until the next rsp_valid.
- Per-operation durations, excluding the 1-cycle accept and DONE overhead:
  - reset: 890 µs
  - bit: 75 µs
  - byte: 600 µs
- Counter compares use equality with (T*CLK_PER_US - 1); no counter wrap occurs within any phase.
- ow_in is treated as synchronous; the pad-side synchroniser sits outside this block.
- Reset mid-operation: return to IDLE with no rsp_valid; the partial byte is discarded.

Test Plan:
1. CLK_PER_US=2, reset cmd, slave pulls ow_in low 30–150 µs after release -> ow_oe high exactly 960 cycles; rsp_valid 820 cycles after release; presence=1, short_err=0.
2. Reset cmd, no slave (ow_in=1) -> presence=0, short_err=0. Then with ow_in held 0 throughout -> presence=1, short_err=1.
3. Write byte 0xA5, ow_in follows ow_oe -> low pulses in order 12,120,12,120,120,12,120,12 cycles, each slot 150 cycles; rsp_valid after 1200 cycles; rx_byte=0xA5.
4. Read byte, slave holds bus low 13–40 µs in slots for 0-bits of 0x3C -> every low pulse 12 cycles; rx_byte=0x3C.
5. Write bit tx_byte=0x00 -> single 120-cycle low pulse; rx_byte=0x00. Second request held asserted during busy -> accepted only in the cycle after rsp_valid.
6. rst_n low during slot 4 of a write byte -> ow_oe=0 immediately; no rsp_valid; cmd_ready=1 after release; rx_byte=0x00.

Source files
------------

// File: rtl/one_wire_link_layer.sv
// rtl/one_wire_link_layer.sv - standard-speed 1-Wire reset/presence and time-slot engine
module one_wire_link_layer #(
  parameter int CLK_PER_US = 50,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_byte,
  output logic       rsp_valid,
  output logic [7:0] rx_byte,
  output logic       presence,
  output logic       short_err,
  input  logic       ow_in,
  output logic       ow_out,
  output logic       ow_oe
);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_HIGH, SLOT_LOW, SLOT_REL, SLOT_REC, DONE
  } state_t;

  localparam logic [1:0] CMD_RST   = 2'b00;
  localparam logic [1:0] CMD_RBYTE = 2'b10;
  localparam logic [1:0] CMD_WBIT  = 2'b11;

  localparam logic [CNT_W-1:0] T_RST_LOW  = CNT_W'(480 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_PRES     = CNT_W'(70 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_RST_HIGH = CNT_W'(410 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_LOW1     = CNT_W'(6 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_LOW0     = CNT_W'(60 * CLK_PER_US - 1);
  // Slot-relative 13 us sample point, expressed in whichever phase it lands in
  localparam logic [CNT_W-1:0] T_SAMP0    = CNT_W'(13 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_SAMP1    = CNT_W'((13 - 6) * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_REL1     = CNT_W'((70 - 6) * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_REL0     = CNT_W'((70 - 60) * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] T_REC      = CNT_W'(5 * CLK_PER_US - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [7:0]       sh_q, sh_d;
  logic [3:0]       bits_q, bits_d;
  logic             samp_q, samp_d;
  logic             pres_q, pres_d;
  logic             oe_q, oe_d;
  logic [7:0]       rx_q, rx_d;
  logic             presence_q, presence_d;
  logic             short_q, short_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    cmd_d      = cmd_q;
    sh_d       = sh_q;
    bits_d     = bits_q;
    samp_d     = samp_q;
    pres_d     = pres_q;
    rx_d       = rx_q;
    presence_d = presence_q;
    short_d    = short_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d  = cmd;
          bits_d = (cmd == CMD_WBIT) ? 4'd1 : 4'd8;
          if (cmd == CMD_RBYTE)     sh_d = 8'hFF;
          else if (cmd == CMD_WBIT) sh_d = {7'b0, tx_byte[0]};
          else                      sh_d = tx_byte;
          state_d = (cmd == CMD_RST) ? RST_LOW : SLOT_LOW;
        end
      end
      RST_LOW: if (cnt_q == T_RST_LOW) state_d = RST_HIGH;
      RST_HIGH: begin
        if (cnt_q == T_PRES) pres_d = ~ow_in;
        if (cnt_q == T_RST_HIGH) begin
          presence_d = pres_q;
          short_d    = ~ow_in;
          state_d    = DONE;
        end
      end
      SLOT_LOW: begin
        if (!sh_q[0] && cnt_q == T_SAMP0) samp_d = ow_in;
        if (cnt_q == (sh_q[0] ? T_LOW1 : T_LOW0)) state_d = SLOT_REL;
      end
      SLOT_REL: begin
        if (sh_q[0] && cnt_q == T_SAMP1) samp_d = ow_in;
        if (cnt_q == (sh_q[0] ? T_REL1 : T_REL0)) state_d = SLOT_REC;
      end
      SLOT_REC: begin
        if (cnt_q == T_REC) begin
          // Transmit bits leave at bit0 while samples enter at bit7
          sh_d   = {samp_q, sh_q[7:1]};
          bits_d = bits_q - 4'd1;
          if (bits_q == 4'd1) begin
            rx_d    = (cmd_q == CMD_WBIT) ? {7'b0, samp_q} : {samp_q, sh_q[7:1]};
            state_d = DONE;
          end else begin
            state_d = SLOT_LOW;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    oe_d = (state_d == RST_LOW) || (state_d == SLOT_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= 2'b00;
      sh_q       <= 8'h00;
      bits_q     <= 4'd0;
      samp_q     <= 1'b0;
      pres_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_q       <= 8'h00;
      presence_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      sh_q       <= sh_d;
      bits_q     <= bits_d;
      samp_q     <= samp_d;
      pres_q     <= pres_d;
      oe_q       <= oe_d;
      rx_q       <= rx_d;
      presence_q <= presence_d;
      short_q    <= short_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rx_byte   = rx_q;
  assign presence  = presence_q;
  assign short_err = short_q;
  assign ow_oe     = oe_q;
  assign ow_out    = 1'b0;

endmodule
